// File: rtl/sfu_ctrl_if.sv
// sfu_ctrl_if: OFIFO pop, SFU control and psum SRAM write signals of one SFU column group
// master: the sequencer (drives pops, SFU strobes, write strobe/address)
// slave:  the environment (OFIFO/sink status in, controls out)
interface sfu_ctrl_if #(parameter int addr_bw = 11);
    logic               ofifo_valid;
    logic               ofifo_rd;
    logic               sfu_valid;
    logic               sfu_enable;
    logic               sfu_clear;
    logic               sfu_reset_ptr;
    logic               sfu_out_en;
    logic               out_ready;
    logic               wr_en;
    logic [addr_bw-1:0] wr_addr;
    modport master (
        input  ofifo_valid, out_ready,
        output ofifo_rd, sfu_valid, sfu_enable, sfu_clear, sfu_reset_ptr, sfu_out_en, wr_en, wr_addr
    );
    modport slave (
        output ofifo_valid, out_ready,
        input  ofifo_rd, sfu_valid, sfu_enable, sfu_clear, sfu_reset_ptr, sfu_out_en, wr_en, wr_addr
    );
endinterface

// File: rtl/sfu_ctrl.sv
// sfu_ctrl: sequences kij_num accumulate passes of input_ch psum pops, then drains input_ch ReLU results to SRAM
// clk/reset   : rising-edge clock, synchronous active-high reset
// start       : one-cycle tile start, accepted only when idle; wr_base latched then
// bus         : OFIFO pop, SFU valid/enable/clear/reset_ptr/out_en, out_ready, wr_en/wr_addr
// kij_idx     : current pass index; busy: not idle; done: one-cycle end-of-tile pulse
// stall_cnt   : stall performance counter, live only when SFU_CTRL_PERF_EN is defined
module sfu_ctrl #(
    parameter int input_ch = 16,
    parameter int kij_num  = 9,
    parameter int addr_bw  = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [addr_bw-1:0] wr_base,
    sfu_ctrl_if.master         bus,
    output logic [3:0]         kij_idx,
    output logic               busy,
    output logic               done,
    output logic [15:0]        stall_cnt
);
    localparam int cw = input_ch > 1 ? $clog2(input_ch) : 1;
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] CLEAR    = 3'd1;
    localparam logic [2:0] ACC      = 3'd2;
    localparam logic [2:0] PASS_END = 3'd3;
    localparam logic [2:0] DRAIN    = 3'd4;
    localparam logic [2:0] FLUSH    = 3'd5;
    localparam logic [2:0] DONE     = 3'd6;

    logic [2:0]         state_q, state_d;
    logic [cw-1:0]      in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic [3:0]         kij_q, kij_d;
    logic [addr_bw-1:0] base_q, base_d, wr_addr_q, wr_addr_d;
    logic               enable_q, enable_d, clear_q, clear_d, rptr_q, rptr_d, done_q, done_d, wr_en_q, wr_en_d;
    logic               pop, oe, in_last, out_last, kij_last;

    assign pop      = state_q == ACC && bus.ofifo_valid;
    assign oe       = state_q == DRAIN && bus.out_ready;
    assign in_last  = in_cnt_q == cw'(input_ch - 1);
    assign out_last = out_cnt_q == cw'(input_ch - 1);
    assign kij_last = kij_q == 4'(kij_num - 1);

    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        kij_d     = kij_q;
        base_d    = base_q;
        case (state_q)
            IDLE: begin
                state_d = start ? CLEAR : IDLE;
                base_d  = start ? wr_base : base_q;
            end
            CLEAR: begin
                state_d   = ACC;
                in_cnt_d  = '0;
                out_cnt_d = '0;
                kij_d     = '0;
            end
            ACC: begin
                in_cnt_d  = pop ? (in_last ? '0 : in_cnt_q + 1'b1) : in_cnt_q;
                state_d   = pop && in_last ? (kij_last ? DRAIN : PASS_END) : ACC;
                out_cnt_d = '0;
            end
            PASS_END: begin
                state_d = ACC;
                kij_d   = kij_q + 4'd1;
            end
            DRAIN: begin
                out_cnt_d = oe ? (out_last ? '0 : out_cnt_q + 1'b1) : out_cnt_q;
                state_d   = oe && out_last ? FLUSH : DRAIN;
            end
            FLUSH:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // strobes are registered from the next state so they line up with the state they belong to
        enable_d  = state_d == ACC || state_d == PASS_END;
        clear_d   = state_d == CLEAR;
        rptr_d    = state_d == PASS_END;
        done_d    = state_d == DONE;
        // write lags out_en by one cycle to meet the SFU's registered psum_out
        wr_en_d   = oe;
        wr_addr_d = oe ? base_q + addr_bw'(out_cnt_q) : wr_addr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            kij_q     <= '0;
            base_q    <= '0;
            enable_q  <= 1'b0;
            clear_q   <= 1'b0;
            rptr_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            kij_q     <= kij_d;
            base_q    <= base_d;
            enable_q  <= enable_d;
            clear_q   <= clear_d;
            rptr_q    <= rptr_d;
            done_q    <= done_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
        end
    end

`ifdef SFU_CTRL_PERF_EN
    logic [15:0] stall_q, stall_d;
    logic        stalled;
    assign stalled = (state_q == ACC && !bus.ofifo_valid) || (state_q == DRAIN && !bus.out_ready);
    always_comb stall_d = state_q == IDLE && start ? 16'd0 :
                          stalled && stall_q != 16'hFFFF ? stall_q + 16'd1 : stall_q;
    always_ff @(posedge clk) stall_q <= reset ? 16'd0 : stall_d;
    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'd0;
`endif

    assign bus.ofifo_rd      = pop;
    assign bus.sfu_valid     = pop;
    assign bus.sfu_enable    = enable_q;
    assign bus.sfu_clear     = clear_q;
    assign bus.sfu_reset_ptr = rptr_q;
    assign bus.sfu_out_en    = oe;
    assign bus.wr_en         = wr_en_q;
    assign bus.wr_addr       = wr_addr_q;
    assign kij_idx           = kij_q;
    assign busy              = state_q != IDLE;
    assign done              = done_q;
endmodule

// File: tb/tb_sfu_ctrl.sv
// tb_sfu_ctrl: directed tiles checked every cycle against a counter-level model plus literal per-tile totals
module tb_sfu_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [10:0] wr_base = '0;
    logic [3:0]  kij_idx;
    logic        busy, done;
    logic [15:0] stall_cnt;
    int          n_chk = 0, n_fail = 0;
    bit          chk_en = 0;
    int          n_pop, n_rp, n_wr, exp_val, psum_hi;
    logic [10:0] first_addr, last_addr;

    sfu_ctrl_if #(.addr_bw(11)) bus ();
    sfu_ctrl dut (.clk(clk), .reset(reset), .start(start), .wr_base(wr_base), .bus(bus),
                  .kij_idx(kij_idx), .busy(busy), .done(done), .stall_cnt(stall_cnt));

    always #5 clk = ~clk;
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // tiny SFU: accumulates per channel, resets pointer per pass, outputs ReLU one cycle after out_en
    int acc [16];
    int ptr, pass, optr, sfu_out;
    always @(posedge clk) begin
        if (reset || bus.sfu_clear) begin
            ptr <= 0; pass <= 0; optr <= 0; sfu_out <= 0;
            for (int i = 0; i < 16; i++) acc[i] <= 0;
        end else begin
            if (bus.sfu_reset_ptr) begin
                ptr <= 0; pass <= pass + 1;
            end else if (bus.sfu_valid && ptr < 16) begin
                acc[ptr] <= acc[ptr] + (pass < 5 ? -1 : psum_hi);
                ptr <= ptr + 1;
            end
            if (bus.sfu_out_en && optr < 16) begin
                sfu_out <= acc[optr] > 0 ? acc[optr] : 0;
                optr <= optr + 1;
            end
        end
    end

    // model: pops p (0..144), drained d (0..16), plus one-cycle phases clear / pass-end / done
    bit          m_act, m_clr, m_pe, m_dn, m_wp;
    int          p, d;
    logic [10:0] m_base, m_wa;
    logic [15:0] m_st;
    initial forever begin
        bit in_acc, in_dr, e_rd, e_oe;
        @(negedge clk);
        in_acc = m_act && !m_clr && !m_pe && p < 144;
        in_dr  = m_act && p == 144 && d < 16;
        e_rd   = in_acc && bus.ofifo_valid;
        e_oe   = in_dr && bus.out_ready;
        if (chk_en) begin
            chk("ofifo_rd", bus.ofifo_rd, e_rd);
            chk("sfu_valid", bus.sfu_valid, e_rd);
            chk("sfu_enable", bus.sfu_enable, in_acc || m_pe);
            chk("sfu_clear", bus.sfu_clear, m_clr);
            chk("sfu_reset_ptr", bus.sfu_reset_ptr, m_pe);
            chk("sfu_out_en", bus.sfu_out_en, e_oe);
            chk("wr_en", bus.wr_en, m_wp);
            chk("busy", busy, m_act);
            chk("done", done, m_dn);
            if (in_acc) chk("kij_idx", kij_idx, p / 16);
            if (m_pe) chk("kij_idx_pe", kij_idx, p / 16 - 1);
`ifdef SFU_CTRL_PERF_EN
            chk("stall_cnt", stall_cnt, m_st);
`else
            chk("stall_cnt", stall_cnt, 0);
`endif
            if (bus.ofifo_rd) n_pop++;
            if (bus.sfu_reset_ptr) n_rp++;
            if (bus.wr_en) begin
                chk("wr_addr", bus.wr_addr, m_wa);
                chk("wr_data", sfu_out, exp_val);
                if (n_wr == 0) first_addr = bus.wr_addr;
                last_addr = bus.wr_addr;
                n_wr++;
            end
        end
        if (reset) begin
            m_act = 0; m_clr = 0; m_pe = 0; m_dn = 0; m_wp = 0; p = 0; d = 0; m_base = '0; m_st = '0;
        end else begin
            m_wp = e_oe;
            m_wa = m_base + d[10:0];
            if (!m_act) begin
                if (start) begin
                    m_act = 1; m_clr = 1; p = 0; d = 0; m_base = wr_base; m_st = '0;
                end
            end else if (m_clr) m_clr = 0;
            else if (m_pe) m_pe = 0;
            else if (in_acc) begin
                if (!bus.ofifo_valid) m_st = m_st == 16'hFFFF ? m_st : m_st + 16'd1;
                else begin
                    p++;
                    if (p % 16 == 0 && p < 144) m_pe = 1;
                end
            end else if (in_dr) begin
                if (!bus.out_ready) m_st = m_st == 16'hFFFF ? m_st : m_st + 16'd1;
                else d++;
            end else if (m_dn) begin
                m_act = 0; m_dn = 0;
            end else m_dn = 1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // valid pattern for mode 2: per pass 32 ACC cycles 0,1,0,1,... then a pass-end cycle driven high
    function automatic logic vf(input int mode, input int n);
        int k;
        if (mode != 2) return 1'b1;
        if (n < 2) return 1'b0;
        k = (n - 2) % 33;
        return k == 32 ? 1'b1 : k[0];
    endfunction

    // mode 3: drain starts at cycle 154, so the 7th out_en is cycle 160; gap is 161..165
    function automatic logic rf(input int mode, input int n);
        return !(mode == 3 && n >= 161 && n <= 165);
    endfunction

    task automatic run_tile(input logic [10:0] b, input int mode, input int lat, input bit neg);
        int n;
        bit got;
        logic [10:0] last;
        psum_hi = neg ? -1 : 2;
        exp_val = neg ? 0 : 3;
        n_pop = 0; n_rp = 0; n_wr = 0;
        start = 1'b1; wr_base = b;
        bus.ofifo_valid = vf(mode, 0); bus.out_ready = rf(mode, 0);
        n = 0; got = 0;
        while (!got && n < 1000) begin
            cyc();
            n++;
            start = mode == 4 && n == 60;
            wr_base = mode == 4 && n == 60 ? 11'h3AA : b;
            bus.ofifo_valid = vf(mode, n);
            bus.out_ready = rf(mode, n);
            got = done;
        end
        last = b + 11'd15;
        chk("latency", n, lat);
        chk("pop_total", n_pop, 144);
        chk("reset_ptr_total", n_rp, 8);
        chk("wr_total", n_wr, 16);
        chk("first_addr", first_addr, b);
        chk("last_addr", last_addr, last);
        cyc();
    endtask

    initial begin
        bus.ofifo_valid = 1'b0;
        bus.out_ready = 1'b0;
        cyc();
        cyc();
        chk_en = 1;
        chk("rst_busy", busy, 0);
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_kij", kij_idx, 0);
        chk("rst_stall", stall_cnt, 0);
        reset = 1'b0;
        cyc();
        run_tile(11'h100, 1, 171, 0);
        run_tile(11'h100, 2, 315, 0);
`ifdef SFU_CTRL_PERF_EN
        chk("stall_alt", stall_cnt, 144);
`else
        chk("stall_alt", stall_cnt, 0);
`endif
        run_tile(11'h100, 3, 176, 0);
`ifdef SFU_CTRL_PERF_EN
        chk("stall_gap", stall_cnt, 5);
`else
        chk("stall_gap", stall_cnt, 0);
`endif
        run_tile(11'h100, 4, 171, 0);
        start = 1'b1; wr_base = 11'h200; bus.ofifo_valid = 1'b1; bus.out_ready = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 1; i < 75; i++) cyc();
        chk("kij_before_reset", kij_idx, 4);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_enable", bus.sfu_enable, 0);
        chk("abort_rd", bus.ofifo_rd, 0);
        chk("abort_kij", kij_idx, 0);
        chk("abort_wr_addr", bus.wr_addr, 0);
        run_tile(11'h000, 1, 171, 0);
        run_tile(11'h7F8, 1, 171, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sfu_ctrl.md
Name: sfu_ctrl

Overview:
Sequencer for the SFU accumulate/ReLU bank. Pops psum words from the output FIFO and drives the SFU's valid/enable/reset_ptr across kij_num kernel passes of input_ch words each. It then drains the input_ch ReLU results and issues SRAM write strobes with addresses.
Sits between the OFIFO, the SFU and the psum SRAM write port. One instance per SFU column group.

Parameters:
input_ch, 16, words per pass; also the number of outputs drained.
kij_num, 9, accumulation passes per tile.
addr_bw, 11, SRAM address width.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  synchronous, active-high; all state and outputs cleared.
start  input  1  one-cycle pulse; begins a tile. Ignored unless the FSM is in IDLE.
wr_base  input  addr_bw  SRAM base address; latched on an accepted start.
ofifo_valid  input  1  OFIFO holds at least one word.
ofifo_rd  output  1  OFIFO pop. Combinational: (state==ACC) & ofifo_valid.
sfu_valid  output  1  equals ofifo_rd.
sfu_enable  output  1  registered; 1 in ACC and PASS_END.
sfu_clear  output  1  drives SFU reset; 1-cycle pulse in CLEAR.
sfu_reset_ptr  output  1  1-cycle pulse in PASS_END.
sfu_out_en  output  1  combinational: (state==DRAIN) & out_ready.
out_ready  input  1  sink can accept a write one cycle after out_en.
wr_en  output  1  registered copy of sfu_out_en.
wr_addr  output  addr_bw  registered: base + drain index of the matching out_en.
kij_idx  output  4  current pass index.
busy  output  1  state != IDLE.
done  output  1  1-cycle pulse in DONE.
stall_cnt  output  16  performance counter; see Optional Feature.

Behaviour:
- Reset state: IDLE. All outputs 0; counters in_cnt, out_cnt, kij_idx and base are 0.
- IDLE -> CLEAR on start. Latch wr_base.
- CLEAR: sfu_clear=1 for exactly one cycle; in_cnt=0, kij_idx=0; -> ACC.
- ACC:
  - Each cycle with ofifo_valid=1: pop, sfu_valid=1, in_cnt+1.
  - Cycles with ofifo_valid=0: no pop, counters hold.
  - On the pop with in_cnt==input_ch-1: in_cnt wraps to 0.
    - If kij_idx==kij_num-1 -> DRAIN (out_cnt=0).
    - Otherwise -> PASS_END.
- PASS_END: sfu_reset_ptr=1 for one cycle; kij_idx+1; -> ACC. No pop in this cycle even if ofifo_valid=1.
- DRAIN:
  - sfu_out_en follows out_ready; out_cnt+1 per out_en.
  - On the out_en with out_cnt==input_ch-1 -> FLUSH.
- FLUSH: exactly one cycle; the final wr_en is emitted here. -> DONE.
- DONE: done=1 for one cycle; -> IDLE.
- Write latency: wr_en and wr_addr are asserted exactly one cycle after each sfu_out_en, matching the SFU's registered psum_out. wr_addr = base + out_cnt, with wrap modulo 2^addr_bw.
- Stalls: no duplicate or skipped addresses across out_ready gaps. Exactly input_ch wr_en per tile.
- Totals per tile: kij_num*input_ch pops and kij_num-1 reset_ptr pulses.
- Fully-streaming latency, start to done: 1 (CLEAR) + kij_num*input_ch + (kij_num-1) + input_ch + 2 cycles. Defaults: 1+144+8+16+2 = 171.
- Reset mid-operation: IDLE on the next edge, all outputs 0. A pending wr_en is dropped, and the next start runs a full tile.
- start while busy: ignored, no effect on any counter.

Optional Feature:
SFU_CTRL_PERF_EN.
- Defined: stall_cnt increments each cycle in ACC with ofifo_valid=0, and each cycle in DRAIN with out_ready=0. Cleared on an accepted start; saturates at 16'hFFFF; holds value in IDLE.
- Undefined: stall_cnt tied to 0 and no counter logic is synthesized. The port is retained either way.

Test Plan:
1. Reset, then start with wr_base=0x100 and ofifo_valid=1, out_ready=1 held -> 144 ofifo_rd, 8 sfu_reset_ptr pulses, 16 wr_en at 0x100..0x10F, done 171 cycles after start.
2. ofifo_valid alternating 1/0 in ACC -> still exactly 144 pops, never a pop with valid=0 or in PASS_END, done 315 cycles after start.
3. out_ready low 5 cycles after the 7th out_en -> no out_en/wr_en in the gap, addresses contiguous 0x100..0x10F, no duplicates; stall_cnt=5 with SFU_CTRL_PERF_EN, 0 without.
4. start pulsed during ACC at kij_idx=3 -> ignored; base and counters unchanged; tile completes normally.
5. reset asserted in ACC at kij_idx=4 -> next cycle IDLE, all outputs 0. A following start with wr_base=0x000 -> full 171-cycle tile writing 0x000..0x00F.
6. Integrated with SFU, psum_in=-1 for passes 0-4 and +2 for passes 5-8 on every channel -> each written value 3. All psum_in=-1 -> all written values 0 (ReLU).
